// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
package vga_timing_pkg;

  // Sync polarity selectors
  localparam int ACTIVE_LOW  = 0;
  localparam int ACTIVE_HIGH = 1;

  // 640x480@60 defaults (25 MHz pixel rate)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Total period of one axis: active + front porch + sync + back porch
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Pixels per line including blanking
  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  // Lines per frame including blanking
  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: a wrapping position counter plus active/sync region decode.
// Region order along the axis is active, front porch, sync, back porch.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic             wrap_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             in_active_o,
  output logic             in_sync_o
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Advance on inc, wrapping to zero after the last position
  always_comb begin
    wrap_o = inc_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Position register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign in_active_o = (cnt_q < ACT_END);
  assign in_sync_o   = (cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Counters advance on the pixel strobe; the
// outputs register the decode of the pre-increment position, so they describe
// the pixel for the strobe period following each strobe edge.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = ACTIVE_LOW,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic             h_wrap, v_wrap_unused;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_act, h_sync, v_act, v_sync;

  vga_axis_cnt #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
  ) u_h_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (pix_en),
    .wrap_o     (h_wrap),
    .cnt_o      (h_cnt),
    .in_active_o(h_act),
    .in_sync_o  (h_sync)
  );

  // The vertical axis steps once per completed line
  vga_axis_cnt #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
  ) u_v_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (h_wrap),
    .wrap_o     (v_wrap_unused),
    .cnt_o      (v_cnt),
    .in_active_o(v_act),
    .in_sync_o  (v_sync)
  );

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  // Level outputs hold between strobes; markers pulse only on a strobe
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en) begin
      hsync_d       = h_sync ? SYNC_ON : ~SYNC_ON;
      vsync_d       = v_sync ? SYNC_ON : ~SYNC_ON;
      de_d          = h_act && v_act;
      x_d           = (h_act && v_act) ? h_cnt : '0;
      y_d           = (h_act && v_act) ? v_cnt : '0;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // Output registers, sync deasserted in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing (instance a) and a tiny 14x7
// active-high-sync raster (instance b).
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn_a, pe_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       rn_b, pe_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rn_a), .pix_en(pe_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(ACTIVE_HIGH), .CNT_W(10)
  ) dut_b (
    .clk(clk), .rst_n(rn_b), .pix_en(pe_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
  );

  logic [22:0] lvl_a, lvl_b, snap;
  logic [24:0] pk_b;
  assign lvl_a = {hs_a, vs_a, de_a, x_a, y_a};
  assign lvl_b = {hs_b, vs_b, de_b, x_b, y_b};
  assign pk_b  = {hs_b, vs_b, de_b, ls_b, fs_b, x_b, y_b};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // One clock: drive strobes at the falling edge, return just after the rising edge
  task automatic cyc(input logic ea, input logic eb);
    @(negedge clk);
    pe_a = ea;
    pe_b = eb;
    @(posedge clk);
    #1;
  endtask

  int hs_lo, hs_first, hs_last, de_last, ls_n, ls2, fs_n, vs_lo, err_xy, err_hold;
  int hh, vv, ex, ey;
  logic ede;
  int hs_hi, hs1, vs_hi, vs1, de_n, fs2, seq_err, gap_err, gap;
  logic [24:0] ref_q [196];

  initial begin
    rn_a = 1'b0; pe_a = 1'b0; rn_b = 1'b0; pe_b = 1'b0;
    repeat (3) cyc(0, 0);

    // ---------------- instance a: default timing ----------------
    chk("a_rst_hsync", hs_a, 1);
    chk("a_rst_vsync", vs_a, 1);
    chk("a_rst_de", de_a, 0);
    chk("a_rst_xy", {x_a, y_a}, 0);
    chk("a_rst_pulses", {ls_a, fs_a}, 0);

    @(negedge clk) rn_a = 1'b1;
    cyc(0, 0);
    cyc(1, 0);
    chk("a_first_de", de_a, 1);
    chk("a_first_xy", {x_a, y_a}, 0);
    chk("a_first_ls", ls_a, 1);
    chk("a_first_fs", fs_a, 1);
    chk("a_first_sync", {hs_a, vs_a}, 2'b11);
    cyc(0, 0);
    chk("a_gap_pulses", {ls_a, fs_a}, 0);
    chk("a_gap_de", de_a, 1);

    hs_lo = 0; hs_first = -1; hs_last = -1; de_last = -1;
    ls_n = 0; ls2 = -1; fs_n = 0; vs_lo = 0; err_xy = 0; err_hold = 0;
    for (int k = 1; k <= 1600; k++) begin
      cyc(1, 0);
      hh  = k % 800;
      vv  = k / 800;
      ede = (hh < 640) && (vv < 480);
      ex  = ede ? hh : 0;
      ey  = ede ? vv : 0;
      if (k < 800) begin
        if (!hs_a) begin
          hs_lo++;
          if (hs_first < 0) hs_first = k;
          hs_last = k;
        end
        if (de_a) de_last = k;
      end
      if (ls_a) begin
        ls_n++;
        if (ls2 < 0) ls2 = k;
      end
      if (fs_a) fs_n++;
      if (!vs_a) vs_lo++;
      if (de_a !== ede || x_a !== 10'(ex) || y_a !== 10'(ey)) err_xy++;
      snap = lvl_a;
      cyc(0, 0);
      if (lvl_a !== snap || ls_a || fs_a) err_hold++;
    end
    chk("a_hs_low_cnt", hs_lo, 96);
    chk("a_hs_first", hs_first, 656);
    chk("a_hs_last", hs_last, 751);
    chk("a_de_last_x", de_last, 639);
    chk("a_ls_count", ls_n, 2);
    chk("a_ls_period", ls2, 800);
    chk("a_fs_count", fs_n, 0);
    chk("a_vs_low", vs_lo, 0);
    chk("a_xy_errs", err_xy, 0);
    chk("a_hold_errs", err_hold, 0);
    chk("a_line2_y", {de_a, x_a, y_a}, {1'b1, 10'd0, 10'd2});

    // ---------------- instance b: tiny raster, active-high sync ----------------
    chk("b_rst_sync", {hs_b, vs_b}, 0);
    chk("b_rst_de", de_b, 0);
    @(negedge clk) rn_b = 1'b1;
    cyc(0, 0);

    hs_hi = 0; hs1 = -1; vs_hi = 0; vs1 = -1; de_n = 0; ls_n = 0; fs_n = 0; fs2 = -1;
    for (int k = 0; k < 196; k++) begin
      cyc(0, 1);
      ref_q[k] = pk_b;
      if (k < 98) begin
        if (hs_b) begin
          hs_hi++;
          if (hs1 < 0) hs1 = k;
        end
        if (vs_b) begin
          vs_hi++;
          if (vs1 < 0) vs1 = k;
        end
        if (de_b) de_n++;
      end
      if (ls_b) ls_n++;
      if (fs_b) begin
        fs_n++;
        if (k > 0 && fs2 < 0) fs2 = k;
      end
    end
    chk("b_hs_hi_cnt", hs_hi, 14);
    chk("b_hs_first", hs1, 10);
    chk("b_vs_hi_cnt", vs_hi, 14);
    chk("b_vs_first", vs1, 70);
    chk("b_de_per_frame", de_n, 32);
    chk("b_ls_count", ls_n, 14);
    chk("b_fs_count", fs_n, 2);
    chk("b_frame_len", fs2, 98);
    chk("b_first_px", ref_q[0], {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0});

    // Same two frames with random strobe gaps
    pe_b = 1'b0;
    @(negedge clk) rn_b = 1'b0;
    cyc(0, 0);
    @(negedge clk) rn_b = 1'b1;
    seq_err = 0; gap_err = 0;
    for (int k = 0; k < 196; k++) begin
      snap = lvl_b;
      gap = int'($urandom_range(3, 0));
      for (int g = 0; g < gap; g++) begin
        cyc(0, 0);
        if (lvl_b !== snap || ls_b || fs_b) gap_err++;
      end
      cyc(0, 1);
      if (pk_b !== ref_q[k]) seq_err++;
    end
    chk("b_gap_seq_errs", seq_err, 0);
    chk("b_gap_hold_errs", gap_err, 0);

    // Reset in the middle of a frame at (5,2)
    @(negedge clk) rn_b = 1'b0;
    cyc(0, 0);
    @(negedge clk) rn_b = 1'b1;
    for (int k = 0; k <= 33; k++) cyc(0, 1);
    chk("b_pre_rst_xy", {de_b, x_b, y_b}, {1'b1, 10'd5, 10'd2});
    pe_b = 1'b0;
    #2 rn_b = 1'b0;
    #1;
    chk("b_async_rst_de", de_b, 0);
    chk("b_async_rst_xy", {x_b, y_b}, 0);
    repeat (3) cyc(0, 0);
    @(negedge clk) rn_b = 1'b1;
    cyc(0, 0);
    cyc(0, 1);
    chk("b_post_rst_px", {de_b, ls_b, fs_b, x_b, y_b}, {3'b111, 10'd0, 10'd0});
    cyc(0, 1);
    chk("b_post_rst_x1", {de_b, ls_b, fs_b, x_b, y_b}, {3'b100, 10'd1, 10'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
